i2c_req_arbiter: RTL and testbench

Shares one byte-level I2C master engine among NREQ on-chip requesters. Each requester posts a single-byte transaction: 7-bit slave address, read/write flag, write data. The block arbitrates round-robin, issues the winning transaction to the master engine, and watches for completion or timeout. It returns read data and a NACK or timeout status to the owning requester. It sits between the system-side register clients and the I2C master that drives scl/sda toward slaves such as the 7'b1010001 device.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/rr_pick.sv | 28 ++
 rtl/i2c_req_arbiter.sv | 143 ++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C requester arbiter: FSM states, status codes, field widths.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_NACK    = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_RECOVER
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or above ptr, wrapping.
// Zero latency; no flow control of its own.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [PW-1:0]   idx_o,
  output logic            valid_o
);

  logic [PW-1:0] cand;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = PW'((int'(ptr_i) + off) % NREQ);
      if (!valid_o && req_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin share of one byte-level I2C master among NREQ requesters, with timeout/abort.
// gnt 1 cycle after req in IDLE; done 1 cycle after m_done; requesters hold req until gnt.
module i2c_req_arbiter
  import i2c_pkg::*;
#(
  parameter int          NREQ    = 4,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_i,
  input  logic [I2C_ADDR_W*NREQ-1:0] req_addr_i,
  input  logic [NREQ-1:0]            req_rw_i,
  input  logic [I2C_DATA_W*NREQ-1:0] req_wdata_i,
  output logic [NREQ-1:0]            gnt_o,
  output logic [NREQ-1:0]            done_o,
  output logic [I2C_DATA_W-1:0]      rdata_o,
  output logic [1:0]                 err_o,
  output logic                       busy_o,
  output logic                       m_start_o,
  output logic [I2C_ADDR_W-1:0]      m_addr_o,
  output logic                       m_rw_o,
  output logic [I2C_DATA_W-1:0]      m_wdata_o,
  output logic                       m_abort_o,
  input  logic                       m_ready_i,
  input  logic                       m_done_i,
  input  logic                       m_nack_i,
  input  logic [I2C_DATA_W-1:0]      m_rdata_i
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [I2C_ADDR_W-1:0] addr_a  [NREQ];
  logic [I2C_DATA_W-1:0] wdata_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr_i[i*I2C_ADDR_W +: I2C_ADDR_W];
    assign wdata_a[i] = req_wdata_i[i*I2C_DATA_W +: I2C_DATA_W];
  end

  state_e                state_q;
  logic [PW-1:0]         ptr_q, ptr_d, owner_q, pick_idx;
  logic                  pick_vld;
  logic [15:0]           cnt_q;
  logic [NREQ-1:0]       gnt_q, done_q;
  logic [I2C_DATA_W-1:0] rdata_q, m_wdata_q;
  logic [I2C_ADDR_W-1:0] m_addr_q;
  err_e                  err_q;
  logic                  busy_q, m_start_q, m_rw_q, m_abort_q;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  // Last winner drops to lowest priority.
  assign ptr_d = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= ERR_OK;
      busy_q    <= 1'b0;
      m_start_q <= 1'b0;
      m_addr_q  <= '0;
      m_rw_q    <= 1'b0;
      m_wdata_q <= '0;
      m_abort_q <= 1'b0;
    end else begin
      gnt_q     <= '0;
      done_q    <= '0;
      m_start_q <= 1'b0;
      m_abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt_q[pick_idx] <= 1'b1;
            m_addr_q        <= addr_a[pick_idx];
            m_rw_q          <= req_rw_i[pick_idx];
            m_wdata_q       <= wdata_a[pick_idx];
            owner_q         <= pick_idx;
            ptr_q           <= ptr_d;
            busy_q          <= 1'b1;
            state_q         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (m_ready_i) begin
            m_start_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + 16'd1;
          // done is registered on the way into RESP so it is visible while in RESP.
          if (m_done_i) begin
            done_q[owner_q] <= 1'b1;
            rdata_q         <= (m_rw_q && !m_nack_i) ? m_rdata_i : '0;
            err_q           <= m_nack_i ? ERR_NACK : ERR_OK;
            state_q         <= ST_RESP;
          end else if (cnt_q == TIMEOUT - 16'd1) begin
            m_abort_q <= 1'b1;
            state_q   <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          if (m_ready_i) begin
            done_q[owner_q] <= 1'b1;
            rdata_q         <= '0;
            err_q           <= ERR_TIMEOUT;
            state_q         <= ST_RESP;
          end
        end
        ST_RESP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign busy_o    = busy_q;
  assign m_start_o = m_start_q;
  assign m_addr_o  = m_addr_q;
  assign m_rw_o    = m_rw_q;
  assign m_wdata_o = m_wdata_q;
  assign m_abort_o = m_abort_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed and randomized bench for i2c_req_arbiter against a transaction-level model.
module tb_i2c_req_arbiter;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main instance (long timeout) signals
  logic [NREQ-1:0]   req, req_rw, gnt, done;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_wdata;
  logic [7:0]        rdata, m_wdata, m_rdata;
  logic [1:0]        err;
  logic [6:0]        m_addr;
  logic              busy, m_start, m_rw, m_abort, m_ready, m_done, m_nack;

  // Short-timeout instance signals
  logic [NREQ-1:0]   t_req, t_req_rw, t_gnt, t_done;
  logic [7*NREQ-1:0] t_req_addr;
  logic [8*NREQ-1:0] t_req_wdata;
  logic [7:0]        t_rdata, t_m_wdata, t_m_rdata;
  logic [1:0]        t_err;
  logic [6:0]        t_m_addr;
  logic              t_busy, t_m_start, t_m_rw, t_m_abort, t_m_ready, t_m_done, t_m_nack;

  i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT(16'd200)) dut (
    .clk(clk), .reset(reset),
    .req_i(req), .req_addr_i(req_addr), .req_rw_i(req_rw), .req_wdata_i(req_wdata),
    .gnt_o(gnt), .done_o(done), .rdata_o(rdata), .err_o(err), .busy_o(busy),
    .m_start_o(m_start), .m_addr_o(m_addr), .m_rw_o(m_rw), .m_wdata_o(m_wdata),
    .m_abort_o(m_abort), .m_ready_i(m_ready), .m_done_i(m_done), .m_nack_i(m_nack),
    .m_rdata_i(m_rdata)
  );

  i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT(16'd20)) dut_to (
    .clk(clk), .reset(reset),
    .req_i(t_req), .req_addr_i(t_req_addr), .req_rw_i(t_req_rw), .req_wdata_i(t_req_wdata),
    .gnt_o(t_gnt), .done_o(t_done), .rdata_o(t_rdata), .err_o(t_err), .busy_o(t_busy),
    .m_start_o(t_m_start), .m_addr_o(t_m_addr), .m_rw_o(t_m_rw), .m_wdata_o(t_m_wdata),
    .m_abort_o(t_m_abort), .m_ready_i(t_m_ready), .m_done_i(t_m_done), .m_nack_i(t_m_nack),
    .m_rdata_i(t_m_rdata)
  );

  int ntests = 0;
  int nfail  = 0;

  // Reference model: rotating priority pointer plus the fields each requester posted.
  int         mptr = 0;
  logic [6:0] maddr [NREQ];
  logic       mrw   [NREQ];
  logic [7:0] mwd   [NREQ];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] r);
    logic [NREQ-1:0] v;
    v = r;
    for (int k = 0; k < NREQ; k++)
      if (v[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    req[i]             = 1'b1;
    req_addr[i*7 +: 7] = a;
    req_rw[i]          = rw;
    req_wdata[i*8 +: 8] = wd;
    maddr[i] = a;
    mrw[i]   = rw;
    mwd[i]   = wd;
  endtask

  // One full transaction on the main instance; the requester set is already on req.
  task automatic serve(input int lat, input logic nack, input logic [7:0] rd,
                       input int rdy_dly, input logic keep);
    int         w;
    logic [7:0] exp_rd;
    m_ready = (rdy_dly == 0);
    w = model_pick(req);
    tick();
    check("gnt", gnt, 32'd1 << w);
    check("busy_at_gnt", busy, 1);
    mptr = (w + 1) % NREQ;
    if (!keep) req[w] = 1'b0;
    for (int k = 0; k < rdy_dly; k++) begin
      tick();
      check("m_start_held_off", m_start, 0);
    end
    m_ready = 1'b1;
    tick();
    check("m_start", m_start, 1);
    check("m_addr", m_addr, maddr[w]);
    check("m_rw", m_rw, mrw[w]);
    check("m_wdata", m_wdata, mwd[w]);
    m_ready = 1'b0;
    for (int k = 0; k < lat; k++) tick();
    m_done  = 1'b1;
    m_nack  = nack;
    m_rdata = rd;
    m_ready = 1'b1;
    tick();
    m_done  = 1'b0;
    m_nack  = 1'b0;
    m_rdata = 8'h00;
    exp_rd = (mrw[w] && !nack) ? rd : 8'h00;
    check("done", done, 32'd1 << w);
    check("rdata", rdata, exp_rd);
    check("err", err, nack ? 1 : 0);
    check("busy_at_done", busy, 1);
    check("no_abort", m_abort, 0);
    tick();
    check("done_pulse_end", done, 0);
    check("busy_after_done", busy, 0);
    check("rdata_hold", rdata, exp_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    m_ready = 1'b1; m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;
    t_req = '0; t_req_rw = '0; t_req_addr = '0; t_req_wdata = '0;
    t_m_ready = 1'b1; t_m_done = 1'b0; t_m_nack = 1'b0; t_m_rdata = '0;
    tick(); tick();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_m_start", m_start, 0);
    check("rst_m_abort", m_abort, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    tick();

    // Round-robin with all requests held: order 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) set_req(i, 7'(8'h10 + i), 1'b0, 8'(8'h80 + i));
    for (int n = 0; n < 5; n++) begin
      check("rr_order", model_pick(req), n % NREQ);
      serve(5, 1'b0, 8'h00, 0, 1'b1);
    end
    req = '0;
    tick();

    // Single write, 100-cycle master latency
    set_req(0, 7'h51, 1'b0, 8'hA5);
    serve(100, 1'b0, 8'h00, 0, 1'b0);
    // Read from requester 2
    set_req(2, 7'h51, 1'b1, 8'h00);
    serve(30, 1'b0, 8'h3C, 1, 1'b0);
    // NACK on a read: rdata forced to 0
    set_req(1, 7'h22, 1'b1, 8'h00);
    serve(12, 1'b1, 8'hFF, 0, 1'b0);
    // NACK on a write, then a normal transaction
    set_req(3, 7'h33, 1'b0, 8'h5A);
    serve(7, 1'b1, 8'h00, 2, 1'b0);
    set_req(3, 7'h34, 1'b0, 8'h5B);
    serve(9, 1'b0, 8'h00, 0, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && ($urandom_range(0, 1) == 1))
          set_req(i, 7'($urandom), 1'($urandom), 8'($urandom));
      if (req == '0) set_req(int'($urandom_range(0, NREQ - 1)), 7'($urandom), 1'($urandom), 8'($urandom));
      serve(int'($urandom_range(1, 60)), ($urandom_range(0, 3) == 0), 8'($urandom),
            int'($urandom_range(0, 2)), 1'b0);
    end
    for (int k = 0; k < NREQ; k++)
      if (req != '0) serve(int'($urandom_range(1, 20)), 1'b0, 8'($urandom), 0, 1'b0);

    // Timeout on the TIMEOUT=20 instance, with a stray m_done during recovery
    t_req = 4'b0001; t_req_addr[6:0] = 7'h51; t_req_rw[0] = 1'b1;
    tick();
    check("to_gnt", t_gnt, 1);
    t_req = '0;
    tick();
    check("to_m_start", t_m_start, 1);
    t_m_ready = 1'b0;
    for (int k = 1; k < 20; k++) begin
      tick();
      check("to_no_early_abort", t_m_abort, 0);
    end
    tick();
    check("to_abort_at_20", t_m_abort, 1);
    check("to_busy", t_busy, 1);
    t_m_done = 1'b1; t_m_rdata = 8'h77;
    tick();
    t_m_done = 1'b0; t_m_rdata = 8'h00;
    check("to_abort_pulse", t_m_abort, 0);
    check("to_stray_done_ignored", t_done, 0);
    tick();
    check("to_wait_ready", t_done, 0);
    t_m_ready = 1'b1;
    tick();
    check("to_done", t_done, 1);
    check("to_err", t_err, 2);
    check("to_rdata", t_rdata, 0);
    tick();
    check("to_busy_clear", t_busy, 0);

    // m_done in the same cycle as the timeout hit: completion wins
    t_req = 4'b0010; t_req_addr[13:7] = 7'h44; t_req_rw[1] = 1'b1;
    tick();
    check("tie_gnt", t_gnt, 2);
    t_req = '0;
    tick();
    check("tie_m_start", t_m_start, 1);
    t_m_ready = 1'b0;
    for (int k = 1; k < 20; k++) tick();
    t_m_done = 1'b1; t_m_rdata = 8'h5A; t_m_ready = 1'b1;
    tick();
    t_m_done = 1'b0; t_m_rdata = 8'h00;
    check("tie_done", t_done, 2);
    check("tie_err", t_err, 0);
    check("tie_rdata", t_rdata, 8'h5A);
    check("tie_no_abort", t_m_abort, 0);
    tick();
    check("tie_no_abort_late", t_m_abort, 0);

    // Reset in the middle of WAIT; pointer must return to 0
    set_req(2, 7'h2A, 1'b0, 8'h99);
    m_ready = 1'b1;
    tick();
    check("mr_gnt", gnt, 4);
    req[2] = 1'b0;
    tick();
    check("mr_m_start", m_start, 1);
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1;
    #1;
    check("mr_busy", busy, 0);
    check("mr_gnt0", gnt, 0);
    check("mr_done", done, 0);
    check("mr_m_start0", m_start, 0);
    check("mr_m_abort", m_abort, 0);
    tick();
    check("mr_m_abort_held", m_abort, 0);
    reset = 1'b0;
    mptr = 0;
    tick();
    set_req(1, 7'h11, 1'b0, 8'h01);
    set_req(3, 7'h13, 1'b1, 8'h00);
    serve(4, 1'b0, 8'h00, 0, 1'b0);
    serve(6, 1'b0, 8'hC3, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
